fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_ctrl_if.sv | 34 +++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
//   fetch_state_t  : controller state encoding (F_IDLE, F_REQ, F_FLUSH)
//   fetch_entry_t  : one fetched instruction {pc, inst}
//   RESET_PC_DEFAULT : default first fetch address after reset
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_REQ   = 2'd1,
        F_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Redirect targets are halfword aligned; bit 0 is always dropped.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's redirect, icache and downstream signals.
//   master : fetch_ctrl side (drives icache request and fetch outputs)
//   slave  : environment side (core redirect, icache, realigner)
interface fetch_ctrl_if;

    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_pc_i;

    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_ack_i;
    logic [31:0] icache_data_i;

    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_inst_o;

    modport master (
        input  redirect_i, redirect_pc_i, stall_pc_i,
        input  icache_ack_i, icache_data_i, fetch_ready_i,
        output icache_req_o, icache_addr_o,
        output fetch_valid_o, fetch_pc_o, fetch_inst_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, stall_pc_i,
        output icache_ack_i, icache_data_i, fetch_ready_i,
        input  icache_req_o, icache_addr_o,
        input  fetch_valid_o, fetch_pc_o, fetch_inst_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: small circular FIFO of {pc, inst} entries with synchronous flush.
//   clk, reset   : clock, asynchronous active-high reset
//   flush        : empties the buffer; wins over push and pop
//   push/push_data : write one entry (caller guarantees not full)
//   pop          : consume head entry (ignored when empty)
//   head/valid   : head entry (zero when empty) and non-empty flag
//   count        : number of stored entries
// DEPTH must be a power of two, minimum 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            valid_q;
    logic            do_pop;

    assign do_pop = pop && valid_q;

    // Next occupancy; flush overrides any same-cycle traffic.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(do_pop);
        end
    end

    // Pointers, count and valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = valid_q ? mem[rd_ptr] : '0;
    assign valid = valid_q;
    assign count = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential icache requests, buffers the
// responses and hands them to the realigner over a valid/ready handshake.
// Redirects flush the buffer; an in-flight request is drained and its
// response dropped (F_FLUSH) before fetching from the new target.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch_ctrl_if.master (redirect, icache req/ack, fetch outputs)
// Parameters: RESET_PC (first fetch address), BUF_DEPTH (power of two, >= 2).
// Build option: define FETCH_BYPASS_EN to present an ack arriving on an empty
// buffer directly on the fetch outputs in the same cycle.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_ctrl_if.master   bus
);

    localparam int unsigned CW  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW1-1:0] DEPTH_EXT = CW1'(BUF_DEPTH);

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [31:0]   addr_q;
    logic          req_q;

    logic          fifo_flush;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_valid;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic [CW-1:0] fifo_count;

    logic          ack_live;
    logic          bypass_take;
    logic [CW1-1:0] count_after;
    logic          has_room;
    logic [31:0]   target;

    // A response counts only for a live request that is not being redirected.
    assign ack_live    = (state_q == F_REQ) && bus.icache_ack_i && !bus.redirect_i;
    assign fifo_pop    = fifo_valid && bus.fetch_ready_i;
    assign fifo_push   = ack_live && !bypass_take;
    assign push_entry  = '{pc: pc_q, inst: bus.icache_data_i};
    assign target      = align_target(bus.redirect_pc_i);
    assign has_room    = {1'b0, fifo_count} < DEPTH_EXT;
    // Occupancy after this cycle's push/pop decides back-to-back issue.
    assign count_after = {1'b0, fifo_count} + CW1'(fifo_push) - CW1'(fifo_pop);

`ifdef FETCH_BYPASS_EN
    logic bypass;

    // Empty buffer: forward the response straight through this cycle.
    assign bypass            = ack_live && !fifo_valid;
    assign bypass_take       = bypass && bus.fetch_ready_i;
    assign bus.fetch_valid_o = fifo_valid || bypass;
    assign bus.fetch_pc_o    = fifo_valid ? fifo_head.pc   : (bypass ? pc_q : '0);
    assign bus.fetch_inst_o  = fifo_valid ? fifo_head.inst : (bypass ? bus.icache_data_i : '0);
`else
    assign bypass_take       = 1'b0;
    assign bus.fetch_valid_o = fifo_valid;
    assign bus.fetch_pc_o    = fifo_head.pc;
    assign bus.fetch_inst_o  = fifo_head.inst;
`endif

    // Next-state, pc and buffer control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fifo_flush = 1'b0;
        unique case (state_q)
            F_IDLE: begin
                if (bus.redirect_i) begin
                    fifo_flush = 1'b1;
                    pc_d       = target;
                end else if (has_room && !bus.stall_pc_i) begin
                    state_d = F_REQ;
                end
            end
            F_REQ: begin
                if (bus.redirect_i) begin
                    fifo_flush = 1'b1;
                    pc_d       = target;
                    // Without the ack the old request is still in flight.
                    state_d    = bus.icache_ack_i ? F_IDLE : F_FLUSH;
                end else if (bus.icache_ack_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ((count_after < DEPTH_EXT) && !bus.stall_pc_i) ? F_REQ : F_IDLE;
                end
            end
            F_FLUSH: begin
                if (bus.redirect_i) begin
                    fifo_flush = 1'b1;
                    pc_d       = target;
                end
                // The stale response ends the flush; staying here after it
                // would wait on an ack that never comes.
                if (bus.icache_ack_i) begin
                    state_d = F_IDLE;
                end
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    // State, pc and registered icache request; F_FLUSH keeps the old address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= (state_d != F_IDLE);
            addr_q  <= (state_d == F_FLUSH) ? addr_q : pc_d;
        end
    end

    assign bus.icache_req_o  = req_q;
    assign bus.icache_addr_o = addr_q;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl (default build, buffer depth 2): directed scenarios
// followed by random traffic, all checked every cycle against a
// transaction-level model (pc, outstanding request, drop flag, entry queue).
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0]  m_pc;
    logic [31:0]  m_addr;
    logic         m_out;
    logic         m_drop;
    fetch_entry_t mq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_addr = RST_PC;
        m_out  = 1'b0;
        m_drop = 1'b0;
        mq.delete();
    endtask

    // One clock of the model, given the inputs present at the edge.
    task automatic model_update(input logic rd, input logic [31:0] tg, input logic st,
                                input logic ak, input logic [31:0] dt, input logic rdy);
        int sz0;
        fetch_entry_t e;
        sz0 = mq.size();
        if (rd) begin
            mq.delete();
            m_pc = tg & 32'hFFFF_FFFE;
            if (m_out && !ak) m_drop = 1'b1;
            else begin m_out = 1'b0; m_drop = 1'b0; end
        end else if (m_out && ak) begin
            if (m_drop) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else begin
                if (sz0 > 0 && rdy) void'(mq.pop_front());
                e.pc   = m_addr;
                e.inst = dt;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
                if (mq.size() < DEPTH && !st) m_addr = m_pc;
                else m_out = 1'b0;
            end
        end else begin
            if (sz0 > 0 && rdy) void'(mq.pop_front());
            if (!m_out && sz0 < DEPTH && !st) begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic compare_model();
        check("req", 32'(bus.icache_req_o), 32'(m_out));
        if (m_out) check("addr", bus.icache_addr_o, m_addr);
        check("valid", 32'(bus.fetch_valid_o), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("head_pc", bus.fetch_pc_o, mq[0].pc);
            check("head_inst", bus.fetch_inst_o, mq[0].inst);
        end
    endtask

    task automatic step(input logic rd, input logic [31:0] tg, input logic st,
                        input logic ak, input logic [31:0] dt, input logic rdy);
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tg;
        bus.stall_pc_i    = st;
        bus.icache_ack_i  = ak;
        bus.icache_data_i = dt;
        bus.fetch_ready_i = rdy;
        @(posedge clk);
        model_update(rd, tg, st, ak, dt, rdy);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.stall_pc_i    = 1'b0;
        bus.icache_ack_i  = 1'b0;
        bus.icache_data_i = '0;
        bus.fetch_ready_i = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_req", 32'(bus.icache_req_o), 32'd0);
        check("rst_addr", bus.icache_addr_o, RST_PC);
        check("rst_valid", 32'(bus.fetch_valid_o), 32'd0);
        check("rst_pc", bus.fetch_pc_o, 32'd0);
        check("rst_inst", bus.fetch_inst_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int n_acc;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        model_reset();
        do_reset();

        // Back-to-back sequential fetch, ack every cycle.
        step(0, 0, 0, 1, 32'hA000_0000, 1);
        check("seq_a0", bus.icache_addr_o, 32'h8000_0000);
        step(0, 0, 0, 1, 32'hA000_0001, 1);
        check("seq_a1", bus.icache_addr_o, 32'h8000_0004);
        check("seq_p0", bus.fetch_pc_o, 32'h8000_0000);
        step(0, 0, 0, 1, 32'hA000_0002, 1);
        check("seq_a2", bus.icache_addr_o, 32'h8000_0008);
        check("seq_p1", bus.fetch_pc_o, 32'h8000_0004);
        check("seq_i1", bus.fetch_inst_o, 32'hA000_0002);

        // Redirect while 8000_0008 is pending; its response arrives later.
        step(1, 32'h8000_0103, 0, 0, 0, 1);
        check("fl_valid", 32'(bus.fetch_valid_o), 32'd0);
        check("fl_addr0", bus.icache_addr_o, 32'h8000_0008);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("fl_addr2", bus.icache_addr_o, 32'h8000_0008);
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        check("fl_drop", 32'(bus.fetch_valid_o), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        check("fl_next", bus.icache_addr_o, 32'h8000_0102);

        // Redirect together with ack and pop.
        step(0, 0, 0, 1, 32'h1111_2222, 1);
        step(1, 32'h9000_0000, 0, 1, 32'h3333_4444, 1);
        check("rap_valid", 32'(bus.fetch_valid_o), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        check("rap_addr", bus.icache_addr_o, 32'h9000_0000);

        // Stall during a request, then pc wrap.
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("wr_addr", bus.icache_addr_o, 32'hFFFF_FFFC);
        step(0, 0, 1, 1, 32'h5555_6666, 1);
        check("st_valid", 32'(bus.fetch_valid_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 1);
            check("st_noreq", 32'(bus.icache_req_o), 32'd0);
        end
        step(0, 0, 0, 0, 0, 1);
        check("wrap_addr", bus.icache_addr_o, 32'h0000_0000);

        // Reset with a request pending; ack right after release is ignored.
        do_reset();
        step(0, 0, 0, 1, 32'hBAD0_BAD0, 1);
        check("rr_valid", 32'(bus.fetch_valid_o), 32'd0);
        check("rr_addr", bus.icache_addr_o, RST_PC);

        // Downstream not ready: only two requests fit.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.icache_req_o) n_acc++;
            step(0, 0, 0, 1, 32'hC000_0000 + 32'(i), 0);
        end
        check("bp_acks", 32'(n_acc), 32'd2);
        check("bp_noreq", 32'(bus.icache_req_o), 32'd0);
        check("bp_h0", bus.fetch_pc_o, 32'h8000_0000);
        step(0, 0, 0, 0, 0, 1);
        check("bp_h1", bus.fetch_pc_o, 32'h8000_0004);
        step(0, 0, 0, 0, 0, 1);
        check("bp_next", bus.icache_addr_o, 32'h8000_0008);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if (i % 700 == 699) do_reset();
            step(($urandom_range(0, 19) == 0), $urandom,
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) < 6),
                 $urandom, ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
